charge_accumulator: RTL

- Accumulator core between the µA/mA range front-end inputs (ua, ma, ovf flags) and the SPI readout stage.
- On each acc_clk edge while enabled, converts the active range's 12-bit sample to a common µA scale and adds it to a wide saturating charge register.
- Offers an atomic snapshot (accumulator, sample count, flags) through a req/valid/ack handshake that the SPI stage consumes.

---
 rtl/charge_accumulator.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/charge_accumulator.sv
// charge_accumulator: saturating charge integrator between the uA/mA range
// front-end and the SPI readout stage.
//
// Each enabled acc_clk edge scales the active range's 12-bit sample onto a
// common uA-tick grid and adds it to a wide saturating accumulator. An
// atomic snapshot of {accumulator, sample count, flags} is handed to the SPI
// stage through a snap_req / snap_valid / snap_ack handshake.
//
// The enabled edge that takes the FSM from IDLE into RUN already carries a
// sample, so N enabled edges contribute exactly N samples.
//
// Build option: define ACC_SNAP_CLEAR_EN to make every honoured snapshot
// restart accumulation (interval readings). Left undefined, snapshots are
// read-only and the live state is unaffected.
//
// ACC_W must be at least 24 so the largest scaled term (22 bits) fits.

module charge_accumulator #(
    parameter int ACC_W = 48,
    parameter int CNT_W = 32
) (
    input  logic             acc_clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [11:0]      ua,
    input  logic             ua_ovf,
    input  logic [11:0]      ma,
    input  logic             ma_ovf,
    input  logic             snap_req,
    input  logic             snap_ack,
    output logic             snap_valid,
    output logic [ACC_W-1:0] snap_acc,
    output logic [CNT_W-1:0] snap_cnt,
    output logic [2:0]       snap_flags,
    output logic             running
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_SAT  = 2'd2;

    localparam int                TERM_W          = 22;
    localparam logic [TERM_W-1:0] FULL_SCALE_TERM = 22'd4095000;

    logic [1:0]        state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              sat_q, sat_d;
    logic              range_err_q, range_err_d;
    logic              snap_valid_q, snap_valid_d;
    logic [ACC_W-1:0]  snap_acc_q, snap_acc_d;
    logic [CNT_W-1:0]  snap_cnt_q, snap_cnt_d;
    logic [2:0]        snap_flags_q, snap_flags_d;

    logic [TERM_W-1:0] ma_ext, ma_scaled, term;
    logic              term_err;
    logic [ACC_W-1:0]  term_ext;
    logic [ACC_W:0]    sum;
    logic              overflow;
    logic [CNT_W-1:0]  cnt_inc;
    logic              accumulating;
    logic              snap_take;

    // Select the active range and scale it to uA ticks (x1000 by shift-and-subtract)
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path leaves it unassigned and infers a latch.
        term      = '0;
        term_err  = 1'b0;
        ma_ext    = {10'b0, ma};
        ma_scaled = (ma_ext << 10) - (ma_ext << 4) - (ma_ext << 3);
        if (!ua_ovf) begin
            term = {10'b0, ua};
        end else if (!ma_ovf) begin
            term = ma_scaled;
        end else begin
            term     = FULL_SCALE_TERM;
            term_err = 1'b1;
        end
    end

    // Adder with carry-out for overflow detection, saturating counter increment
    always_comb begin
        term_ext     = {{(ACC_W-TERM_W){1'b0}}, term};
        sum          = {1'b0, acc_q} + {1'b0, term_ext};
        overflow     = sum[ACC_W];
        cnt_inc      = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        accumulating = en && (state_q != ST_SAT);
        snap_take    = snap_req && !snap_valid_q;
    end

    // Live state: FSM, accumulator, counter and sticky flags (clr has top priority)
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        sat_d       = sat_q;
        range_err_d = range_err_q;
        if (clr) begin
            state_d     = ST_IDLE;
            acc_d       = '0;
            cnt_d       = '0;
            sat_d       = 1'b0;
            range_err_d = 1'b0;
        end
`ifdef ACC_SNAP_CLEAR_EN
        else if (snap_take) begin
            // The snapshot closes the interval; this cycle's sample opens the next one.
            acc_d       = accumulating ? term_ext : '0;
            cnt_d       = accumulating ? CNT_W'(1) : '0;
            sat_d       = 1'b0;
            range_err_d = accumulating && term_err;
            state_d     = en ? ST_RUN : ST_IDLE;
        end
`endif
        else begin
            case (state_q)
                ST_SAT: begin
                    // Accumulator and counter stay frozen until the enable drops.
                    if (!en) state_d = ST_IDLE;
                end
                default: begin
                    if (en) begin
                        cnt_d       = cnt_inc;
                        range_err_d = range_err_q | term_err;
                        if (overflow) begin
                            acc_d   = '1;
                            sat_d   = 1'b1;
                            state_d = ST_SAT;
                        end else begin
                            acc_d   = sum[ACC_W-1:0];
                            state_d = ST_RUN;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Snapshot capture of pre-edge values and valid/ack handshake
    always_comb begin
        snap_valid_d = snap_valid_q;
        snap_acc_d   = snap_acc_q;
        snap_cnt_d   = snap_cnt_q;
        snap_flags_d = snap_flags_q;
        if (snap_take) begin
            snap_valid_d = 1'b1;
            snap_acc_d   = acc_q;
            snap_cnt_d   = cnt_q;
            snap_flags_d = {sat_q, range_err_q, state_q == ST_RUN};
        end else if (snap_ack) begin
            snap_valid_d = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge acc_clk or negedge reset) begin
        // NOTE: the snapshot data registers are reset too, because they drive outputs that must read 0 out of reset.
        if (!reset) begin
            state_q      <= ST_IDLE;
            acc_q        <= '0;
            cnt_q        <= '0;
            sat_q        <= 1'b0;
            range_err_q  <= 1'b0;
            snap_valid_q <= 1'b0;
            snap_acc_q   <= '0;
            snap_cnt_q   <= '0;
            snap_flags_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values, which the snapshot depends on.
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            sat_q        <= sat_d;
            range_err_q  <= range_err_d;
            snap_valid_q <= snap_valid_d;
            snap_acc_q   <= snap_acc_d;
            snap_cnt_q   <= snap_cnt_d;
            snap_flags_q <= snap_flags_d;
        end
    end

    assign snap_valid = snap_valid_q;
    assign snap_acc   = snap_acc_q;
    assign snap_cnt   = snap_cnt_q;
    assign snap_flags = snap_flags_q;
    assign running    = (state_q == ST_RUN);

endmodule
